// File: rtl/systolic_feed_ctrl.sv
// Feeder/sequencer for an NxN systolic array: banks one A and one B matrix, then streams skewed lanes.
// Optional completed-job counter is enabled by defining SYS_JOB_CNT_EN.
module systolic_feed_ctrl #(
  parameter int N         = 4,
  parameter int DATA_W    = 8,
  parameter int DRAIN_CYC = 4
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic                  i_wr_en,
  input  logic                  i_wr_sel,
  input  logic [$clog2(N)-1:0]  i_wr_idx,
  input  logic [N*DATA_W-1:0]   i_wr_data,
  input  logic                  i_start,
  output logic [N*DATA_W-1:0]   o_a_full,
  output logic [N*DATA_W-1:0]   o_b_full,
  output logic                  o_array_clr,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [15:0]           o_job_cnt
);

  localparam int IW = $clog2(N);
  localparam int TW = $clog2(2*N-1);
  localparam int DW = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
  localparam logic [TW-1:0] T_LAST = TW'(2*N-2);
  localparam logic [DW-1:0] D_LAST = DW'(DRAIN_CYC-1);

  typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_FEED, S_DRAIN, S_DONE} state_t;

  state_t              r_state, w_state_next;
  logic [TW-1:0]       r_t, w_t_next;
  logic [DW-1:0]       r_d, w_d_next;
  logic [DATA_W-1:0]   r_a [N][N];
  logic [DATA_W-1:0]   r_b [N][N];
  logic [N*DATA_W-1:0] r_a_full, r_b_full;
  logic [N*DATA_W-1:0] w_a_lane, w_b_lane;
  logic                w_load;

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_state <= S_IDLE;
      r_t     <= '0;
      r_d     <= '0;
    end else begin
      r_state <= w_state_next;
      r_t     <= w_t_next;
      r_d     <= w_d_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_t_next     = r_t;
    w_d_next     = r_d;
    case (r_state)
      S_IDLE:  if (i_start) w_state_next = S_CLEAR;
      S_CLEAR: begin
        w_state_next = S_FEED;
        w_t_next     = '0;
      end
      S_FEED: begin
        if (r_t == T_LAST) begin
          w_state_next = S_DRAIN;
          w_d_next     = '0;
        end else begin
          w_t_next = r_t + 1'b1;
        end
      end
      S_DRAIN: begin
        if (r_d == D_LAST) w_state_next = S_DONE;
        else               w_d_next = r_d + 1'b1;
      end
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Banks only change in IDLE, so a job always sees a stable matrix pair.
  assign w_load = i_wr_en && (r_state == S_IDLE);

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      for (int r = 0; r < N; r++) begin
        for (int c = 0; c < N; c++) begin
          r_a[r][c] <= '0;
          r_b[r][c] <= '0;
        end
      end
    end else if (w_load) begin
      for (int k = 0; k < N; k++) begin
        if (!i_wr_sel) r_a[i_wr_idx][k] <= i_wr_data[k*DATA_W +: DATA_W];
        else           r_b[k][i_wr_idx] <= i_wr_data[k*DATA_W +: DATA_W];
      end
    end
  end

  // Lane gi carries element index k = t - gi. When t < gi the subtraction wraps with the top
  // bit set, so the single "k < N" test also rejects the leading edge of the diagonal band.
  for (genvar gi = 0; gi < N; gi++) begin : g_lane
    logic [TW:0] w_k;
    logic        w_in;
    assign w_k  = {1'b0, w_t_next} - (TW+1)'(gi);
    assign w_in = (w_k < (TW+1)'(N));
    assign w_a_lane[gi*DATA_W +: DATA_W] = w_in ? r_a[gi][w_k[IW-1:0]] : '0;
    assign w_b_lane[gi*DATA_W +: DATA_W] = w_in ? r_b[w_k[IW-1:0]][gi] : '0;
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_a_full <= '0;
      r_b_full <= '0;
    end else if (w_state_next == S_FEED) begin
      r_a_full <= w_a_lane;
      r_b_full <= w_b_lane;
    end else begin
      r_a_full <= '0;
      r_b_full <= '0;
    end
  end

  assign o_a_full    = r_a_full;
  assign o_b_full    = r_b_full;
  assign o_array_clr = (r_state == S_CLEAR);
  assign o_busy      = (r_state != S_IDLE);
  assign o_done      = (r_state == S_DONE);

`ifdef SYS_JOB_CNT_EN
  logic [15:0] r_job_cnt;
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset)                r_job_cnt <= '0;
    else if (r_state == S_DONE) r_job_cnt <= r_job_cnt + 16'd1;
  end
  assign o_job_cnt = r_job_cnt;
`else
  assign o_job_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_systolic_feed_ctrl.sv
// Scoreboard bench for systolic_feed_ctrl: driver queues expected lanes/done times, monitor compares.
module tb_systolic_feed_ctrl;
  localparam int N = 4;

  logic        i_clock = 1'b0;
  logic        i_reset = 1'b1;
  logic        i_wr_en = 1'b0;
  logic        i_wr_sel = 1'b0;
  logic [1:0]  i_wr_idx = '0;
  logic [31:0] i_wr_data = '0;
  logic        i_start = 1'b0;
  logic [31:0] o_a_full, o_b_full;
  logic        o_array_clr, o_busy, o_done;
  logic [15:0] o_job_cnt;

  systolic_feed_ctrl #(.N(4), .DATA_W(8), .DRAIN_CYC(4)) dut (
    .i_clock(i_clock), .i_reset(i_reset), .i_wr_en(i_wr_en), .i_wr_sel(i_wr_sel),
    .i_wr_idx(i_wr_idx), .i_wr_data(i_wr_data), .i_start(i_start),
    .o_a_full(o_a_full), .o_b_full(o_b_full), .o_array_clr(o_array_clr),
    .o_busy(o_busy), .o_done(o_done), .o_job_cnt(o_job_cnt)
  );

  always #5 i_clock = ~i_clock;

  int cyc = 0;
  always @(posedge i_clock) cyc <= cyc + 1;

  logic [7:0]  ma [4][4];
  logic [7:0]  mb [4][4];
  logic [63:0] feed_q[$];
  int          done_q[$];
  int n_chk = 0, n_fail = 0;
  int ph = 0, jobs_done = 0, jobs_since_rst = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [63:0] exp_feed(input int t);
    logic [31:0] a, b;
    a = '0; b = '0;
    for (int i = 0; i < N; i++) begin
      int k = t - i;
      if (k >= 0 && k < N) begin
        a[i*8 +: 8] = ma[i][k];
        b[i*8 +: 8] = mb[k][i];
      end
    end
    return {a, b};
  endfunction

  // Monitor: ph counts cycles from the CLEAR cycle (1) through the DONE cycle (13).
  always @(negedge i_clock) begin
    if (i_reset) begin
      ph = 0;
    end else if (ph == 0) begin
      if (o_array_clr) begin
        ph = 1;
        chk("unexpected_start", done_q.size() > 0, 1);
        chk("clr_busy", o_busy, 1);
        chk("clr_zero_lanes", {o_a_full, o_b_full}, 64'd0);
      end else begin
        chk("idle_busy", o_busy, 0);
        chk("idle_done", o_done, 0);
      end
    end else begin
      ph = ph + 1;
      chk("job_busy", o_busy, 1);
      chk("job_no_clr", o_array_clr, 0);
      if (ph <= 8) begin
        if (feed_q.size() == 0) chk("feed_q_empty", 1, 0);
        else chk($sformatf("feed_t%0d", ph - 2), {o_a_full, o_b_full}, feed_q.pop_front());
      end else begin
        chk("tail_zero_lanes", {o_a_full, o_b_full}, 64'd0);
      end
      if (ph == 13) begin
        chk("done_pulse", o_done, 1);
        if (done_q.size() == 0) chk("done_q_empty", 1, 0);
        else chk("done_cycle", cyc, done_q.pop_front());
        jobs_done++;
        jobs_since_rst++;
        $display("job %0d done at cyc %0d", jobs_done, cyc);
        ph = 0;
      end else begin
        chk("no_early_done", o_done, 0);
      end
    end
  end

  task automatic wr(input logic sel, input logic [1:0] idx, input logic [31:0] d);
    i_wr_en = 1'b1; i_wr_sel = sel; i_wr_idx = idx; i_wr_data = d;
    for (int k = 0; k < N; k++) begin
      if (!sel) ma[idx][k] = d[k*8 +: 8];
      else      mb[k][idx] = d[k*8 +: 8];
    end
    @(negedge i_clock);
    i_wr_en = 1'b0;
  endtask

  task automatic start_job(input logic with_wr, input logic sel, input logic [1:0] idx,
                           input logic [31:0] d);
    if (with_wr) begin
      i_wr_en = 1'b1; i_wr_sel = sel; i_wr_idx = idx; i_wr_data = d;
      for (int k = 0; k < N; k++) begin
        if (!sel) ma[idx][k] = d[k*8 +: 8];
        else      mb[k][idx] = d[k*8 +: 8];
      end
    end
    i_start = 1'b1;
    done_q.push_back(cyc + 13);
    for (int t = 0; t < 2*N-1; t++) feed_q.push_back(exp_feed(t));
    $display("start job at cyc %0d", cyc);
    @(negedge i_clock);
    i_start = 1'b0;
    i_wr_en = 1'b0;
  endtask

  task automatic wait_jobs(input int target);
    int n = 0;
    while (jobs_done < target && n < 40) begin
      @(negedge i_clock);
      n++;
    end
    chk("job_complete", jobs_done >= target, 1);
    @(negedge i_clock);
  endtask

  task automatic zero_model();
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        ma[r][c] = '0;
        mb[r][c] = '0;
      end
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_a"}, o_a_full, 0);
    chk({tag, "_b"}, o_b_full, 0);
    chk({tag, "_clr"}, o_array_clr, 0);
    chk({tag, "_busy"}, o_busy, 0);
    chk({tag, "_done"}, o_done, 0);
    chk({tag, "_jobcnt"}, o_job_cnt, 0);
  endtask

  initial begin
    logic [31:0] d;
    zero_model();
    repeat (3) @(negedge i_clock);
    chk_outputs_zero("reset");
    #2 i_reset = 1'b0;
    @(negedge i_clock);

    // Identity A, B rows filled with 1..4
    for (int i = 0; i < N; i++) wr(1'b0, 2'(i), 32'h1 << (8*i));
    for (int j = 0; j < N; j++) wr(1'b1, 2'(j), 32'h04030201);
    start_job(1'b0, 1'b0, 2'd0, 32'd0);
    wait_jobs(1);

    // Skew pattern; last B column written in the same cycle as start
    for (int i = 0; i < N; i++) begin
      for (int k = 0; k < N; k++) d[k*8 +: 8] = 8'(16*i + k);
      wr(1'b0, 2'(i), d);
    end
    for (int j = 0; j < N; j++) begin
      for (int k = 0; k < N; k++) d[k*8 +: 8] = 8'(16*k + j + 128);
      if (j < N-1) wr(1'b1, 2'(j), d);
      else         start_job(1'b1, 1'b1, 2'(j), d);
    end
    wait_jobs(2);

    // Start and write while in FEED must both be ignored
    start_job(1'b0, 1'b0, 2'd0, 32'd0);
    repeat (3) @(negedge i_clock);
    i_start = 1'b1; i_wr_en = 1'b1; i_wr_sel = 1'b0; i_wr_idx = 2'd0; i_wr_data = 32'hFFFFFFFF;
    @(negedge i_clock);
    i_start = 1'b0; i_wr_en = 1'b0;
    wait_jobs(3);
    start_job(1'b0, 1'b0, 2'd0, 32'd0);
    wait_jobs(4);

    // Asynchronous reset during DRAIN aborts the job
    start_job(1'b0, 1'b0, 2'd0, 32'd0);
    repeat (9) @(negedge i_clock);
    #2 i_reset = 1'b1;
    #1 chk_outputs_zero("abort");
    done_q.delete();
    feed_q.delete();
    zero_model();
    jobs_since_rst = 0;
    @(negedge i_clock);
    #2 i_reset = 1'b0;
    @(negedge i_clock);
    start_job(1'b0, 1'b0, 2'd0, 32'd0);
    wait_jobs(5);
    repeat (3) @(negedge i_clock);

`ifdef SYS_JOB_CNT_EN
    chk("job_cnt", o_job_cnt, 64'(jobs_since_rst));
`else
    chk("job_cnt", o_job_cnt, 0);
`endif
    chk("done_q_drained", done_q.size(), 0);
    chk("feed_q_drained", feed_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
